// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a valid/ready memory port,
// stall hold buffer, branch redirect and stale-response drop.
//
// Parameters:
//   WORD_LEN     data/address width (default 32)
// Ports:
//   clk          pipeline clock, rising edge
//   rst          synchronous active-high reset
//   freeze       hazard stall, holds PC and IF/ID
//   brTaken      branch resolved taken in decode
//   br_offset    sign-extended word offset of the branch
//   imem_req     instruction request valid
//   imem_addr    byte address of the request
//   imem_ready   memory accepts and returns data this cycle
//   imem_rdata   fetched instruction word
//   instruction  IF/ID instruction (0 when not valid)
//   pc_id        IF/ID PC+4 of the held instruction
//   if_valid     IF/ID holds a real instruction
//   fetch_cnt    (IF_PERF_CNT_EN) instructions delivered to IF/ID
//   stall_cnt    (IF_PERF_CNT_EN) freeze or memory-wait cycles
//
// Optional feature macro: IF_PERF_CNT_EN adds the two counters.

module if_stage #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                brTaken,
    input  logic [WORD_LEN-1:0] br_offset,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] instruction,
    output logic [WORD_LEN-1:0] pc_id,
    output logic                if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [WORD_LEN-1:0] FOUR = WORD_LEN'(4);
    localparam logic [WORD_LEN-1:0] ZERO = '0;

    state_t              state;
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] hold_q;
    logic [WORD_LEN-1:0] drop_addr;
    logic [WORD_LEN-1:0] pc_next4;
    logic [WORD_LEN-1:0] br_target;

    assign pc_next4  = pc + FOUR;
    assign br_target = pc_id + FOUR + (br_offset << 2);

    // Reset gates the request immediately so a response
    // arriving during reset is never handshaken.
    assign imem_req  = !rst && (state != S_HOLD);

    // While dropping, the outstanding request keeps its
    // original address; pc already points at the target.
    assign imem_addr = (state == S_DROP) ? drop_addr : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= ZERO;
            instruction <= ZERO;
            pc_id       <= ZERO;
            if_valid    <= 1'b0;
            hold_q      <= ZERO;
            drop_addr   <= ZERO;
        end else if (brTaken) begin
            // Redirect beats freeze: flush IF/ID and the
            // hold buffer, then resolve any open request.
            pc          <= br_target;
            instruction <= ZERO;
            if_valid    <= 1'b0;
            hold_q      <= ZERO;
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        state <= S_REQ;
                    end else begin
                        drop_addr <= pc;
                        state     <= S_DROP;
                    end
                end
                S_HOLD: begin
                    state <= S_REQ;
                end
                S_DROP: begin
                    if (imem_ready) begin
                        state <= S_REQ;
                    end else begin
                        state <= S_DROP;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ready && !freeze) begin
                        instruction <= imem_rdata;
                        pc_id       <= pc_next4;
                        if_valid    <= 1'b1;
                        pc          <= pc_next4;
                    end else if (imem_ready) begin
                        hold_q <= imem_rdata;
                        state  <= S_HOLD;
                    end else if (!freeze) begin
                        // Decode moves on; give it a bubble.
                        instruction <= ZERO;
                        if_valid    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        instruction <= hold_q;
                        pc_id       <= pc_next4;
                        if_valid    <= 1'b1;
                        pc          <= pc_next4;
                        state       <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (!freeze) begin
                        instruction <= ZERO;
                        if_valid    <= 1'b0;
                    end
                    if (imem_ready) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_evt;
    logic stall_evt;

    assign fetch_evt = !brTaken && !freeze &&
                       ((state == S_REQ && imem_ready) ||
                        (state == S_HOLD));
    assign stall_evt = freeze || (imem_req && !imem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (fetch_evt) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_evt) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vectors for if_stage.
// Memory returns 0xA0000000 | address when ready.

module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        brTaken;
    logic [31:0] br_offset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_id;
    logic        if_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    if_stage #(.WORD_LEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .brTaken     (brTaken),
        .br_offset   (br_offset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_id       (pc_id),
        .if_valid    (if_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = imem_ready ? (32'hA000_0000 | imem_addr)
                                   : 32'hDEAD_BEEF;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        freeze     = 1'b0;
        brTaken    = 1'b0;
        br_offset  = 32'd0;
        imem_ready = 1'b1;

        tick();
        tick();
        check("rst_req",   {31'd0, imem_req},   32'd0);
        check("rst_addr",  imem_addr,           32'd0);
        check("rst_instr", instruction,         32'd0);
        check("rst_pcid",  pc_id,               32'd0);
        check("rst_valid", {31'd0, if_valid},   32'd0);

        rst = 1'b0;
        #1;
        check("first_req",  {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr,         32'd0);

        tick();
        check("f0_instr", instruction,       32'hA000_0000);
        check("f0_pcid",  pc_id,             32'd4);
        check("f0_valid", {31'd0, if_valid}, 32'd1);
        check("f0_addr",  imem_addr,         32'd4);

        tick();
        check("f1_instr", instruction, 32'hA000_0004);
        check("f1_pcid",  pc_id,       32'd8);
        check("f1_addr",  imem_addr,   32'd8);

        // Freeze for three cycles with the pc=8 response ready.
        freeze = 1'b1;
        tick();
        check("fz1_req",   {31'd0, imem_req}, 32'd0);
        check("fz1_instr", instruction,       32'hA000_0004);
        check("fz1_pcid",  pc_id,             32'd8);
        tick();
        check("fz2_req",   {31'd0, imem_req}, 32'd0);
        tick();
        check("fz3_instr", instruction,       32'hA000_0004);
        freeze = 1'b0;
        tick();
        check("rel_instr", instruction,       32'hA000_0008);
        check("rel_pcid",  pc_id,             32'd12);
        check("rel_valid", {31'd0, if_valid}, 32'd1);
        check("rel_addr",  imem_addr,         32'd12);

        tick();
        check("f3_instr", instruction, 32'hA000_000C);
        check("f3_pcid",  pc_id,       32'h10);

        // Backward branch: 0x10 + 4 - 8 = 0x0C.
        brTaken   = 1'b1;
        br_offset = -32'sd2;
        tick();
        check("br_addr",  imem_addr,         32'h0C);
        check("br_instr", instruction,       32'd0);
        check("br_valid", {31'd0, if_valid}, 32'd0);
        brTaken = 1'b0;
        tick();
        check("br_next_valid", {31'd0, if_valid}, 32'd1);
        check("br_next_instr", instruction,       32'hA000_000C);
        check("br_next_pcid",  pc_id,             32'h10);

        // Branch and freeze together: 0x10 + 4 + 12 = 0x20.
        brTaken   = 1'b1;
        freeze    = 1'b1;
        br_offset = 32'd3;
        tick();
        check("bf_addr",  imem_addr,         32'h20);
        check("bf_valid", {31'd0, if_valid}, 32'd0);
        check("bf_instr", instruction,       32'd0);
        brTaken    = 1'b0;
        freeze     = 1'b0;
        imem_ready = 1'b0;
        tick();
        check("wait_addr", imem_addr,         32'h20);
        check("wait_req",  {31'd0, imem_req}, 32'd1);

        // Branch while waiting: 0x10 + 4 + 44 = 0x40.
        brTaken   = 1'b1;
        br_offset = 32'd11;
        tick();
        check("drop_addr", imem_addr,         32'h20);
        check("drop_req",  {31'd0, imem_req}, 32'd1);
        brTaken = 1'b0;
        tick();
        check("drop_hold", imem_addr,         32'h20);
        imem_ready = 1'b1;
        tick();
        check("drop_next",  imem_addr,         32'h40);
        check("drop_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("t40_instr", instruction, 32'hA000_0040);
        check("t40_pcid",  pc_id,       32'h44);

        // Two branches while dropping; the newer one wins.
        imem_ready = 1'b0;
        brTaken    = 1'b1;
        br_offset  = 32'd0;
        tick();
        check("dd1_addr", imem_addr, 32'h44);
        br_offset = 32'd4;
        tick();
        check("dd2_addr", imem_addr, 32'h44);
        brTaken    = 1'b0;
        imem_ready = 1'b1;
        tick();
        check("dd_next",  imem_addr,         32'h58);
        check("dd_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("t58_instr", instruction, 32'hA000_0058);
        check("t58_pcid",  pc_id,       32'h5C);

        // Reset mid-request with ready high.
        imem_ready = 1'b0;
        tick();
        check("mid_addr", imem_addr, 32'h5C);
        rst        = 1'b1;
        imem_ready = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("mr_pcid",  pc_id,             32'd0);
        check("mr_valid", {31'd0, if_valid}, 32'd0);
        check("mr_addr",  imem_addr,         32'd0);
`ifdef IF_PERF_CNT_EN
        check("mr_fcnt", fetch_cnt, 32'd0);
        check("mr_scnt", stall_cnt, 32'd0);
`endif

        // Five fetches around a two-cycle freeze.
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("p3_pcid", pc_id, 32'd12);
        freeze = 1'b1;
        tick();
        tick();
        freeze = 1'b0;
        tick();
        check("p4_instr", instruction, 32'hA000_000C);
        tick();
        check("p5_instr", instruction, 32'hA000_0010);
        check("p5_pcid",  pc_id,       32'h14);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 32'd5);
        check("stall_cnt", stall_cnt, 32'd2);
        rst = 1'b1;
        tick();
        check("clr_fcnt", fetch_cnt, 32'd0);
        check("clr_scnt", stall_cnt, 32'd0);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
